// File: rtl/lcd_serial_rx.sv
// lcd_serial_rx: ST7565-style 4-wire SPI receiver with command decode and a 1024x8 display shadow RAM.
module lcd_serial_rx #(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic       sys_clk,
  input  logic       reset_o,
  input  logic       cs,
  input  logic       sck,
  input  logic       sda,
  input  logic       rs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       frame_err,
  output logic [3:0] page,
  output logic [7:0] column,
  output logic [5:0] start_line,
  output logic       display_on,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data
);
  localparam logic [4:0] P_LIM  = 5'(PAGES);
  localparam logic [8:0] C_LIM  = 9'(COLS);
  localparam logic [7:0] C_LAST = 8'(COLS - 1);
  logic [3:0] w_in;
  logic       w_cs, w_sck, w_sda, w_rs;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_in = {cs, sck, sda, rs};
    end else begin : g_sync
      logic [3:0] r_sync [SYNC_STAGES];
      always_ff @(posedge sys_clk or negedge reset_o) begin
        if (!reset_o) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= {cs, sck, sda, rs};
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_in = r_sync[SYNC_STAGES-1];
    end
  endgenerate
  assign {w_cs, w_sck, w_sda, w_rs} = w_in;
  logic       r_sck_d, r_cs_d, r_arm, r_valid, r_rs, r_ferr, r_disp;
  logic [2:0] r_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_data, r_col, r_rd;
  logic [3:0] r_page;
  logic [5:0] r_sl;
  logic       w_shift, w_done, w_cmd, w_dat, w_we, w_disp_n;
  logic [7:0] w_byte, w_col_inc, w_col_n;
  logic [3:0] w_page_n;
  logic [5:0] w_sl_n;
  // r_arm stays low after reset until cs has been seen high, so a byte cut by reset is never resumed
  always_comb begin
    w_shift   = ~r_sck_d & w_sck & ~w_cs & r_arm;
    w_done    = w_shift & (r_cnt == 3'd7);
    w_byte    = {r_shift, w_sda};
    w_cmd     = w_done & ~w_rs;
    w_dat     = w_done & w_rs;
    w_we      = w_dat & ({1'b0, r_page} < P_LIM) & ({1'b0, r_col} < C_LIM);
    w_col_inc = (r_col == C_LAST) ? 8'd0 : r_col + 8'd1;
    w_page_n  = !w_cmd ? r_page : (w_byte[7:4] == 4'hB) ? w_byte[3:0] : (w_byte == 8'hE2) ? 4'd0 : r_page;
    w_col_n   = w_dat ? w_col_inc : !w_cmd ? r_col :
                (w_byte[7:4] == 4'h1) ? {w_byte[3:0], r_col[3:0]} :
                (w_byte[7:4] == 4'h0) ? {r_col[7:4], w_byte[3:0]} :
                (w_byte == 8'hE2) ? 8'd0 : r_col;
    w_sl_n    = !w_cmd ? r_sl : (w_byte[7:6] == 2'b01) ? w_byte[5:0] : (w_byte == 8'hE2) ? 6'd0 : r_sl;
    w_disp_n  = (w_cmd && w_byte[7:1] == 7'h57) ? w_byte[0] : r_disp;
  end
  always_ff @(posedge sys_clk or negedge reset_o) begin
    if (!reset_o) begin
      r_sck_d <= 1'b0;
      r_cs_d  <= 1'b0;
      r_arm   <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_ferr  <= 1'b0;
      r_page  <= '0;
      r_col   <= '0;
      r_sl    <= '0;
      r_disp  <= 1'b0;
    end else begin
      r_sck_d <= w_sck;
      r_cs_d  <= w_cs;
      r_arm   <= r_arm | w_cs;
      r_valid <= w_done;
      r_ferr  <= w_cs & ~r_cs_d & (r_cnt != 3'd0);
      r_page  <= w_page_n;
      r_col   <= w_col_n;
      r_sl    <= w_sl_n;
      r_disp  <= w_disp_n;
      if (w_cs) r_cnt <= '0;
      else if (w_shift) begin
        r_cnt   <= r_cnt + 3'd1;
        r_shift <= w_byte[6:0];
      end
      if (w_done) begin
        r_data <= w_byte;
        r_rs   <= w_rs;
      end
    end
  end
  logic [7:0] r_mem [1024];
  always_ff @(posedge sys_clk) begin
    if (w_we) r_mem[{r_page[2:0], r_col[6:0]}] <= w_byte;
  end
  always_ff @(posedge sys_clk or negedge reset_o) begin
    if (!reset_o) r_rd <= '0;
    else r_rd <= r_mem[rd_addr];
  end
  assign byte_valid = r_valid;
  assign byte_data  = r_data;
  assign byte_rs    = r_rs;
  assign frame_err  = r_ferr;
  assign page       = r_page;
  assign column     = r_col;
  assign start_line = r_sl;
  assign display_on = r_disp;
  assign rd_data    = r_rd;
endmodule

// File: doc/lcd_serial_rx.md
Name: lcd_serial_rx

Overview:
Receiver-side model of the LCD serial controller (ST7565-style 4-wire SPI: cs, sck, sda, rs). It deserialises bytes framed by cs and decodes commands: page address, column address, start line, display on/off and software reset. Data bytes are written into an internal 1024-byte display shadow RAM with column auto-increment. It serves as the on-chip/bench counterpart of the LCD display driver, and as a checker of the frames that driver emits.

Parameters:
COLS, 128, number of valid columns; column index 0..COLS-1
PAGES, 8, number of valid pages; page index 0..PAGES-1
SYNC_STAGES, 0, register stages applied equally to cs/sck/sda/rs before edge detection (0 = inputs already synchronous to sys_clk)

Ports:
sys_clk  in  1  system clock (12 MHz); sck runs at sys_clk/2 or slower
reset_o  in  1  asynchronous, active-low reset
cs  in  1  chip select, low while a byte is in flight
sck  in  1  serial clock; sda is sampled on its rising edge
sda  in  1  serial data, MSB first
rs  in  1  register select: 1 = data, 0 = command; sampled with bit 0 (the 8th bit)
byte_valid  out  1  one-cycle pulse when a byte completes
byte_data  out  8  completed byte, held until the next byte_valid
byte_rs  out  1  rs value of the completed byte
frame_err  out  1  one-cycle pulse when cs rises with 1..7 bits received
page  out  4  current page register
column  out  8  current column register
start_line  out  6  display start line
display_on  out  1  display on/off state
rd_addr  in  10  shadow RAM read address {page[2:0], column[6:0]}
rd_data  out  8  shadow RAM read data, 1-cycle latency

Behaviour:
- Reset (reset_o=0, async): all outputs and internal registers go to 0 (byte_valid, frame_err, byte_data, byte_rs, page, column, start_line, display_on, bit counter). Shadow RAM contents are not cleared. rd_data is 0 until the first read after reset.
- Edge detection: sck rise = (previous sampled sck == 0) and (current == 1), evaluated each sys_clk after SYNC_STAGES. cs, sda and rs use the same delay as sck.
- Shift: on an sck rise while cs==0, shift_reg <= {shift_reg[6:0], sda} and bit_cnt <= bit_cnt+1 (3 bits).
- Byte complete: when bit_cnt==7 at an sck rise:
  - Next cycle: byte_valid=1, byte_data=the assembled byte, byte_rs=rs.
  - bit_cnt wraps to 0, so back-to-back bytes within one cs-low window are accepted.
- cs high: bit_cnt is forced to 0. A cs 0->1 edge with bit_cnt!=0 produces a frame_err pulse and discards the partial byte. sck edges while cs==1 are ignored.
- Decode, applied in the same cycle byte_valid is asserted (rs=0):
  - 0xB0-0xBF: page <= byte[3:0]
  - 0x10-0x1F: column[7:4] <= byte[3:0]
  - 0x00-0x0F: column[3:0] <= byte[3:0]
  - 0x40-0x7F: start_line <= byte[5:0]
  - 0xAE / 0xAF: display_on <= byte[0]
  - 0xE2: page, column and start_line <= 0; display_on unchanged
  - All other command bytes: only byte_valid is asserted, no state change.
- Data (rs=1):
  - If page<PAGES and column<COLS, write RAM[{page[2:0], column[6:0]}] <= byte.
  - Otherwise the write is dropped.
  - Column always advances: if column==COLS-1, column <= 0, else column <= column+1 (8-bit wrap at 255 -> 0). page never auto-increments.
- RAM: 1024x8, synchronous write and synchronous read (1 cycle). A read and write to the same address in the same cycle returns the old data.
- A reset that asserts mid-byte aborts the byte with no byte_valid and no frame_err. Reception after reset starts with the next cs-low window.
- Latency: the last sck rise (after sync) to byte_valid, register update and RAM write is 1 sys_clk.

Test Plan:
- Reset: hold reset_o=0 for 10 cycles, release -> all outputs 0; first byte after release decodes correctly.
- Command stream with rs=0, one cs-low window: 0xB3, 0x12, 0x05, 0xAF, 0x48 -> page=3, column=0x25, display_on=1, start_line=8; five byte_valid pulses, each 1 cycle after its 8th sck rise.
- Data write: page 2, column 126; send 0xA5, 0x3C, 0x7E with rs=1 -> RAM[0x17E]=0xA5, RAM[0x17F]=0x3C, RAM[0x100]=0x7E; column=1, page=2.
- Out-of-range: page=9 then data 0xFF -> no RAM change, column increments. Column=0x90 then data -> dropped, column=0x91.
- Framing: cs low, 5 sck rises, cs high -> frame_err for 1 cycle, no byte_valid. The next full byte 0xAE -> display_on=0.
- Software reset and full-rate sck (sys_clk/2): send 0xE2 after page=5, column=40, start_line=12 -> page/column/start_line=0, display_on retained. Then run a full 1024-byte page/column refresh and compare every RAM location via rd_addr/rd_data.
